// File: rtl/keypad_event_decoder.sv
// Keypad front end: synchronises the scanner's raw key code and pressed flag, debounces them,
// and produces one-hot level, press/repeat strobe and release strobe outputs.
module keypad_event_decoder #(
  parameter int NUM_KEYS        = 16,
  parameter int CNT_W           = 20,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          keyValue,
  input  logic                keyPressed,
  output logic [NUM_KEYS-1:0] keyDown,
  output logic [NUM_KEYS-1:0] keyStrobe,
  output logic [NUM_KEYS-1:0] keyRelease,
  output logic [3:0]          activeKey,
  output logic                activeValid
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_DEBOUNCE = 2'd1;
  localparam logic [1:0] S_HELD     = 2'd2;
  localparam logic [1:0] S_REPEAT   = 2'd3;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(REPEAT_RATE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [4:0]       NK        = 5'(NUM_KEYS);
  localparam logic [NUM_KEYS-1:0] KEY_ONE = NUM_KEYS'(1);
  localparam bit               REP_ON    = (REPEAT_EN != 0);

  function automatic logic [NUM_KEYS-1:0] onehot(input logic [3:0] k);
    onehot = KEY_ONE << k;
  endfunction

  logic [3:0]          kv_s1_q, kv_s2_q;
  logic                kp_s1_q, kp_s2_q;
  logic [1:0]          state_q, state_d;
  logic [3:0]          cand_q, cand_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_KEYS-1:0] down_q, down_d;
  logic [NUM_KEYS-1:0] strobe_q, strobe_d;
  logic [NUM_KEYS-1:0] release_q, release_d;
  logic [3:0]          akey_q, akey_d;
  logic                avalid_q, avalid_d;
  logic                pressed;

  // Two-flop synchroniser stage; the FSM only ever looks at the second flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kv_s1_q <= '0;
      kv_s2_q <= '0;
      kp_s1_q <= 1'b0;
      kp_s2_q <= 1'b0;
    end else begin
      kv_s1_q <= keyValue;
      kv_s2_q <= kv_s1_q;
      kp_s1_q <= keyPressed;
      kp_s2_q <= kp_s1_q;
    end
  end

  assign pressed = kp_s2_q && ({1'b0, kv_s2_q} < NK);

  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    down_d    = down_q;
    strobe_d  = '0;
    release_d = '0;
    akey_d    = akey_q;
    avalid_d  = avalid_q;
    case (state_q)
      S_IDLE: begin
        if (pressed) begin
          state_d = S_DEBOUNCE;
          cand_d  = kv_s2_q;
          cnt_d   = '0;
        end
      end
      S_DEBOUNCE: begin
        if (!pressed) begin
          state_d = S_IDLE;
        end else if (kv_s2_q != cand_q) begin
          cand_d = kv_s2_q;
          cnt_d  = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d  = S_HELD;
          cnt_d    = '0;
          down_d   = onehot(cand_q);
          strobe_d = onehot(cand_q);
          akey_d   = cand_q;
          avalid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_HELD, S_REPEAT: begin
        // A different key while held is a release; the new key must debounce from IDLE.
        if (!pressed || (kv_s2_q != akey_q)) begin
          state_d   = S_IDLE;
          down_d    = '0;
          release_d = onehot(akey_q);
          avalid_d  = 1'b0;
        end else if (state_q == S_HELD) begin
          if (REP_ON && (cnt_q == DLY_LAST)) begin
            state_d  = S_REPEAT;
            cnt_d    = '0;
            strobe_d = onehot(akey_q);
          end else if (REP_ON || (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else if (cnt_q == RATE_LAST) begin
          cnt_d    = '0;
          strobe_d = onehot(akey_q);
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM and registered output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cand_q    <= '0;
      cnt_q     <= '0;
      down_q    <= '0;
      strobe_q  <= '0;
      release_q <= '0;
      akey_q    <= '0;
      avalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      down_q    <= down_d;
      strobe_q  <= strobe_d;
      release_q <= release_d;
      akey_q    <= akey_d;
      avalid_q  <= avalid_d;
    end
  end

  assign keyDown     = down_q;
  assign keyStrobe   = strobe_q;
  assign keyRelease  = release_q;
  assign activeKey   = akey_q;
  assign activeValid = avalid_q;

endmodule

// File: tb/tb_keypad_event_decoder.sv
// Bench for keypad_event_decoder: one instance with repeat enabled and 16 keys,
// one with 10 keys and repeat disabled; strobe/release events checked against a queue.
module tb_keypad_event_decoder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] kv = 4'd0, kv2 = 4'd0;
  logic kp = 1'b0, kp2 = 1'b0;
  logic [15:0] kd, ks, kr;
  logic [3:0]  ak, ak2;
  logic        av, av2;
  logic [9:0]  kd2, ks2, kr2;

  keypad_event_decoder #(
    .NUM_KEYS(16), .CNT_W(8), .DEBOUNCE_CYCLES(4),
    .REPEAT_EN(1), .REPEAT_DELAY(10), .REPEAT_RATE(3)
  ) dut (
    .clk(clk), .rst(rst), .keyValue(kv), .keyPressed(kp),
    .keyDown(kd), .keyStrobe(ks), .keyRelease(kr),
    .activeKey(ak), .activeValid(av)
  );

  keypad_event_decoder #(
    .NUM_KEYS(10), .CNT_W(8), .DEBOUNCE_CYCLES(4),
    .REPEAT_EN(0), .REPEAT_DELAY(10), .REPEAT_RATE(3)
  ) dut2 (
    .clk(clk), .rst(rst), .keyValue(kv2), .keyPressed(kp2),
    .keyDown(kd2), .keyStrobe(ks2), .keyRelease(kr2),
    .activeKey(ak2), .activeValid(av2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int c;
    bit rel;
    int key;
  } ev_t;
  ev_t q[$];

  int total = 0;
  int bad   = 0;
  int base;

  function automatic ev_t mk(input int c, input bit rel, input int key);
    ev_t e;
    e.c = c; e.rel = rel; e.key = key;
    return e;
  endfunction

  // Scoreboard: every strobe/release pulse of the main instance must match the next queued event.
  always @(negedge clk) begin : mon
    ev_t e;
    if (ks !== 16'd0) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL strobe_unexpected cyc=%0d got=%h want=none", cyc, ks);
      end else begin
        e = q.pop_front();
        if (e.rel || e.c != cyc || ks !== (16'd1 << e.key)) begin
          bad++;
          $display("FAIL strobe_event got cyc=%0d strobe=%h want cyc=%0d rel=%0d key=%0d",
                   cyc, ks, e.c, e.rel, e.key);
        end
      end
    end
    if (kr !== 16'd0) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL release_unexpected cyc=%0d got=%h want=none", cyc, kr);
      end else begin
        e = q.pop_front();
        if (!e.rel || e.c != cyc || kr !== (16'd1 << e.key)) begin
          bad++;
          $display("FAIL release_event got cyc=%0d release=%h want cyc=%0d rel=%0d key=%0d",
                   cyc, kr, e.c, e.rel, e.key);
        end
      end
    end
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({kd, ks, kr} !== 48'd0) begin
      bad++; $display("FAIL reset_vectors got=%h want=0", {kd, ks, kr});
    end
    total++;
    if ({ak, av} !== 5'd0) begin
      bad++; $display("FAIL reset_active got=%h want=0", {ak, av});
    end
    total++;
    if ({kd2, ks2, kr2, ak2, av2} !== 35'd0) begin
      bad++; $display("FAIL reset_dut2 got=%h want=0", {kd2, ks2, kr2, ak2, av2});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_hold_repeat;
    @(negedge clk);
    kv = 4'd6; kp = 1'b1;
    base = cyc;
    q.push_back(mk(base + 7, 1'b0, 6));
    for (int e = base + 17; e <= base + 32; e += 3) q.push_back(mk(e, 1'b0, 6));
    wait_cyc(base + 6);
    total++;
    if (kd !== 16'd0) begin
      bad++; $display("FAIL hold_pre_down got=%h want=0", kd);
    end
    wait_cyc(base + 10);
    total++;
    if (kd !== 16'h0040 || ak !== 4'd6 || av !== 1'b1) begin
      bad++; $display("FAIL hold_level got down=%h key=%0d valid=%b want 0040/6/1", kd, ak, av);
    end
    wait_cyc(base + 25);
    total++;
    if (kd !== 16'h0040) begin
      bad++; $display("FAIL hold_level_repeat got=%h want=0040", kd);
    end
    wait_cyc(base + 30);
    kp = 1'b0;
    q.push_back(mk(base + 33, 1'b1, 6));
  endtask

  task automatic test_release;
    wait_cyc(base + 32);
    total++;
    if (kd !== 16'h0040 || av !== 1'b1) begin
      bad++; $display("FAIL release_early got down=%h valid=%b want 0040/1", kd, av);
    end
    wait_cyc(base + 33);
    total++;
    if (kd !== 16'd0 || av !== 1'b0 || ak !== 4'd6) begin
      bad++; $display("FAIL release_level got down=%h valid=%b key=%0d want 0/0/6", kd, av, ak);
    end
    wait_cyc(base + 36);
    total++;
    if (q.size() != 0) begin
      bad++; $display("FAIL release_pending got=%0d want=0", q.size());
    end
  endtask

  task automatic test_glitch;
    @(negedge clk);
    kv = 4'd2; kp = 1'b1;
    base = cyc;
    wait_cyc(base + 3);
    kp = 1'b0;
    wait_cyc(base + 20);
    total++;
    if (kd !== 16'd0 || av !== 1'b0 || ak !== 4'd6) begin
      bad++; $display("FAIL glitch_level got down=%h valid=%b key=%0d want 0/0/6", kd, av, ak);
    end
  endtask

  task automatic test_key_change;
    @(negedge clk);
    kv = 4'd4; kp = 1'b1;
    base = cyc;
    q.push_back(mk(base + 7, 1'b0, 4));
    wait_cyc(base + 12);
    kv = 4'd8;
    q.push_back(mk(base + 15, 1'b1, 4));
    q.push_back(mk(base + 20, 1'b0, 8));
    wait_cyc(base + 16);
    total++;
    if (kd !== 16'd0 || av !== 1'b0) begin
      bad++; $display("FAIL change_gap got down=%h valid=%b want 0/0", kd, av);
    end
    wait_cyc(base + 20);
    total++;
    if (kd !== 16'h0100 || ak !== 4'd8) begin
      bad++; $display("FAIL change_new got down=%h key=%0d want 0100/8", kd, ak);
    end
    wait_cyc(base + 24);
    kp = 1'b0;
    q.push_back(mk(base + 27, 1'b1, 8));
    wait_cyc(base + 30);
    total++;
    if (q.size() != 0) begin
      bad++; $display("FAIL change_pending got=%0d want=0", q.size());
    end
  endtask

  task automatic test_reset_mid_repeat;
    int c2;
    @(negedge clk);
    kv = 4'd5; kp = 1'b1;
    base = cyc;
    q.push_back(mk(base + 7, 1'b0, 5));
    q.push_back(mk(base + 17, 1'b0, 5));
    q.push_back(mk(base + 20, 1'b0, 5));
    wait_cyc(base + 21);
    rst = 1'b1;
    #1;
    total++;
    if ({kd, ks, kr} !== 48'd0 || ak !== 4'd0 || av !== 1'b0) begin
      bad++; $display("FAIL rst_mid got down=%h key=%0d valid=%b want 0/0/0", kd, ak, av);
    end
    total++;
    if (q.size() != 0) begin
      bad++; $display("FAIL rst_mid_pending got=%0d want=0", q.size());
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    c2 = cyc;
    q.push_back(mk(c2 + 7, 1'b0, 5));
    wait_cyc(c2 + 6);
    total++;
    if (kd !== 16'd0) begin
      bad++; $display("FAIL rst_redebounce_early got=%h want=0", kd);
    end
    wait_cyc(c2 + 8);
    total++;
    if (kd !== 16'h0020 || av !== 1'b1) begin
      bad++; $display("FAIL rst_redebounce got down=%h valid=%b want 0020/1", kd, av);
    end
    wait_cyc(c2 + 9);
    kp = 1'b0;
    q.push_back(mk(c2 + 12, 1'b1, 5));
    wait_cyc(c2 + 15);
    total++;
    if (q.size() != 0) begin
      bad++; $display("FAIL rst_pending got=%0d want=0", q.size());
    end
  endtask

  task automatic test_narrow_norepeat;
    int act, nstb, nwrong, nrel;
    act = 0; nstb = 0; nwrong = 0; nrel = 0;
    @(negedge clk);
    kv2 = 4'd12; kp2 = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if ((kd2 | ks2 | kr2) !== 10'd0 || av2 !== 1'b0) act++;
    end
    total++;
    if (act != 0) begin
      bad++; $display("FAIL outofrange_activity got=%0d want=0", act);
    end
    kp2 = 1'b0;
    repeat (5) @(negedge clk);
    kv2 = 4'd2; kp2 = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ks2 !== 10'd0) begin
        nstb++;
        if (ks2 !== 10'h004) nwrong++;
      end
      if (i == 50) begin
        total++;
        if (kd2 !== 10'h004 || ak2 !== 4'd2 || av2 !== 1'b1) begin
          bad++; $display("FAIL norep_level got down=%h key=%0d valid=%b want 004/2/1", kd2, ak2, av2);
        end
      end
    end
    total++;
    if (nstb != 1 || nwrong != 0) begin
      bad++; $display("FAIL norep_strobes got count=%0d wrong=%0d want 1/0", nstb, nwrong);
    end
    kp2 = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (kr2 === 10'h004) nrel++;
    end
    total++;
    if (nrel != 1 || av2 !== 1'b0 || kd2 !== 10'd0) begin
      bad++; $display("FAIL norep_release got pulses=%0d valid=%b down=%h want 1/0/0", nrel, av2, kd2);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d want finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    #1 rst = 1'b1;
    test_reset();
    test_hold_repeat();
    test_release();
    test_glitch();
    test_key_change();
    test_reset_mid_repeat();
    test_narrow_norepeat();
    repeat (3) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++; $display("FAIL final_pending got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
